round_sat: RTL and testbench
============================

Name: round_sat

Overview:
- Width-reduction stage paired with the signed growth adder. It takes a bit-grown sum (DW+GROW_BIT bits) and returns it to the DW-bit datapath format.
- Reduction is done by an arithmetic right shift with rounding, then saturation.
- Sits after each radix-3 butterfly add stage of the FFT.
- Two-stage registered pipeline with valid/ready flow control, plus a sticky overflow flag and a saturation event counter for scaling debug.

Parameters:
- SIGN_BIT, 1, sign bits of the datapath format
- INT_BIT, 6, integer bits of the datapath format
- FLT_BIT, 6, fractional bits of the datapath format
- GROW_BIT, 1, extra MSBs carried by the input (growth from the adds)
- SHIFT, 1, LSBs dropped by scaling (divide by 2^SHIFT); SHIFT>=1
- CNT_W, 16, width of the saturation event counter
- Derived: DW = SIGN_BIT+INT_BIT+FLT_BIT; IW = DW+GROW_BIT.

Ports:
- clk, input, 1, clock, rising edge
- rst, input, 1, reset, asynchronous, active-high
- din, input, IW, grown two's-complement sample
- din_valid, input, 1, din is valid
- din_ready, output, 1, block accepts din this cycle
- dout, output, DW, rounded and saturated sample
- dout_valid, output, 1, dout is valid
- dout_ready, input, 1, downstream accepts dout
- sat_flag, output, 1, sticky: at least one saturation since reset or clear
- sat_cnt, output, CNT_W, number of saturated samples
- sat_clr, input, 1, synchronous clear of sat_flag and sat_cnt

Behaviour:
- Reset (async, rst=1): all stage valid bits, dout, sat_flag and sat_cnt go to 0. din_ready reads 1 once rst deasserts. In-flight samples are discarded.
- Handshake: a transfer occurs on a clock edge where valid&&ready.
  - adv2 = !dout_valid || dout_ready
  - adv1 = !s1_valid || adv2
  - din_ready = adv1 (combinational)
- dout and dout_valid are registered. dout holds stable while dout_valid && !dout_ready.
- Latency: 2 cycles from din acceptance to dout_valid, with no bubbles. Sustained throughput is 1 sample/cycle when dout_ready=1. Order is preserved.
- Stage 1 (round): r = sext(din, IW+1) + 2^(SHIFT-1). Register r >>> SHIFT (arithmetic shift), width IW+1-SHIFT. The extra bit prevents wrap on max positive input.
- Stage 2 (saturate):
  - If r > 2^(DW-1)-1, dout = 2^(DW-1)-1.
  - If r < -2^(DW-1), dout = -2^(DW-1).
  - Otherwise dout = r[DW-1:0].
  - A saturation event is flagged with the sample as it is loaded into the output register.
- sat_cnt increments once per saturated sample on the stage-2 load edge, and holds at all-ones rather than wrapping.
- sat_flag is set on the same edge as a sat_cnt increment.
- sat_clr=1: sat_cnt and sat_flag go to 0 on that edge. This takes priority over a simultaneous saturation event, so that event is not counted.
- The stall path never drops or duplicates samples. A sample held in stage 2 is counted exactly once.

Optional Feature:
- Macro: ROUND_CONVERGENT_EN.
- Defined: stage 1 uses round-half-to-even. A dropped fraction of exactly one half rounds to the even result; all other cases match half-up.
- Undefined: round-half-up, adding 2^(SHIFT-1) as described above.
- Latency and handshake are identical in both builds.

Test Plan:
All cases use defaults: DW=13, IW=14, SHIFT=1.
- Rounding: din=5 -> dout=3. din=-5 (14'h3FFB) -> dout=-2. With ROUND_CONVERGENT_EN: 5 -> 2, 7 -> 4. sat_flag stays 0.
- Saturation: din=8191 -> dout=4095, sat_flag=1, sat_cnt=1. din=8190 -> 4095 with no count. din=-8192 -> -4096 with no count.
- Back-pressure: stream 0,2,4,6,8 with dout_ready=0 for 4 cycles. din_ready drops after 2 accepts and dout=0 holds. After release, the output sequence is 0,1,2,3,4 with no gaps.
- Counter: CNT_W=4, 20 consecutive din=8191 -> sat_cnt=15 held. sat_clr asserted together with a saturating sample -> sat_cnt=0, sat_flag=0.
- Reset mid-stream: assert rst with 2 samples in flight -> dout_valid=0 immediately (async). No stale output after release, and the first new sample appears 2 cycles after its acceptance.
- Full throughput: 64 random samples with dout_ready=1 -> 64 outputs on consecutive cycles, each matching the reference model (arithmetic shift, round, saturate).

Source files
------------

// File: rtl/round_sat.sv
// Width reduction after the growth adder: round by SHIFT LSBs, saturate to DW bits, 2-stage valid/ready pipe.
// Define ROUND_CONVERGENT_EN for round-half-to-even; the default build rounds half-up.
module round_sat #(
  parameter int SIGN_BIT = 1,
  parameter int INT_BIT  = 6,
  parameter int FLT_BIT  = 6,
  parameter int GROW_BIT = 1,
  parameter int SHIFT    = 1,
  parameter int CNT_W    = 16,
  localparam int DW      = SIGN_BIT + INT_BIT + FLT_BIT,
  localparam int IW      = DW + GROW_BIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IW-1:0]    din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [DW-1:0]    dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             sat_flag,
  output logic [CNT_W-1:0] sat_cnt,
  input  logic             sat_clr
);

  localparam int RW = IW + 1 - SHIFT;
  localparam int CW = ((RW > DW) ? RW : DW) + 1;

  localparam logic [IW:0] HALF = {{IW{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [CW-1:0] SAT_MAX = {{(CW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [CW-1:0] SAT_MIN = {{(CW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic          s1_valid_q, s1_valid_d;
  logic [RW-1:0] s1_data_q, s1_data_d;
  logic          dout_valid_q, dout_valid_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          sat_flag_q, sat_flag_d;
  logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;

  logic adv1, adv2;
  logic [IW:0] din_ext, round_add, round_sum;
  logic signed [CW-1:0] r_ext;
  logic sat_hi, sat_lo, sat_evt, s2_load;
  logic unused_round_bits;

  assign adv2      = !dout_valid_q || dout_ready;
  assign adv1      = !s1_valid_q || adv2;
  assign din_ready = adv1;
  assign s2_load   = s1_valid_q && adv2;

  // One guard bit above the input keeps max positive + half from wrapping.
  assign din_ext = {din[IW-1], din};

`ifdef ROUND_CONVERGENT_EN
  // Adding (half - 1) plus the kept LSB rounds ties toward the even result.
  assign round_add = (HALF - {{IW{1'b0}}, 1'b1}) + {{IW{1'b0}}, din[SHIFT]};
`else
  assign round_add = HALF;
`endif

  assign round_sum = din_ext + round_add;
  assign unused_round_bits = ^round_sum[SHIFT-1:0];

  assign r_ext  = {{(CW-RW){s1_data_q[RW-1]}}, s1_data_q};
  assign sat_hi = r_ext > SAT_MAX;
  assign sat_lo = r_ext < SAT_MIN;
  assign sat_evt = s2_load && (sat_hi || sat_lo);

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_data_d    = s1_data_q;
    dout_valid_d = dout_valid_q;
    dout_d       = dout_q;
    sat_flag_d   = sat_flag_q;
    sat_cnt_d    = sat_cnt_q;

    if (adv1) begin
      s1_valid_d = din_valid;
      if (din_valid) begin
        s1_data_d = round_sum[IW:SHIFT];
      end
    end

    if (adv2) begin
      dout_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        if (sat_hi) begin
          dout_d = SAT_MAX[DW-1:0];
        end else if (sat_lo) begin
          dout_d = SAT_MIN[DW-1:0];
        end else begin
          dout_d = r_ext[DW-1:0];
        end
      end
    end

    // Clear wins over a coincident saturation, which is then not counted.
    if (sat_clr) begin
      sat_flag_d = 1'b0;
      sat_cnt_d  = '0;
    end else if (sat_evt) begin
      sat_flag_d = 1'b1;
      if (sat_cnt_q != {CNT_W{1'b1}}) begin
        sat_cnt_d = sat_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
      sat_flag_q   <= 1'b0;
      sat_cnt_q    <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_data_q    <= s1_data_d;
      dout_valid_q <= dout_valid_d;
      dout_q       <= dout_d;
      sat_flag_q   <= sat_flag_d;
      sat_cnt_q    <= sat_cnt_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign sat_flag   = sat_flag_q;
  assign sat_cnt    = sat_cnt_q;

endmodule

// File: tb/tb_round_sat.sv
// Scoreboard bench for round_sat: the driver queues expected outputs, a negedge monitor pops and compares.
module tb_round_sat;
  localparam int DW    = 13;
  localparam int IW    = 14;
  localparam int SHIFT = 1;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [IW-1:0]    din = '0;
  logic             din_valid = 1'b0;
  logic             din_ready;
  logic [DW-1:0]    dout;
  logic             dout_valid;
  logic             dout_ready = 1'b0;
  logic             sat_flag;
  logic [CNT_W-1:0] sat_cnt;
  logic             sat_clr = 1'b0;

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int acc_cnt = 0;
  logic [DW-1:0] exp_q[$];
  int            out_cyc[$];
  logic          stall_prev = 1'b0;
  logic [DW-1:0] dout_prev = '0;

  round_sat #(.SHIFT(SHIFT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .sat_flag(sat_flag), .sat_cnt(sat_cnt), .sat_clr(sat_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: floor division by 2^SHIFT, round on the remainder, then clamp.
  function automatic logic [DW-1:0] model(input logic [IW-1:0] x);
    int v, q, rem, half;
    v    = int'($signed(x));
    half = 1 << (SHIFT - 1);
    q    = v >>> SHIFT;
    rem  = v - (q << SHIFT);
`ifdef ROUND_CONVERGENT_EN
    if (rem > half || (rem == half && q[0])) q = q + 1;
`else
    if (rem >= half) q = q + 1;
`endif
    if (q > (1 << (DW - 1)) - 1) q = (1 << (DW - 1)) - 1;
    if (q < -(1 << (DW - 1)))    q = -(1 << (DW - 1));
    return q[DW-1:0];
  endfunction

  task automatic send(input logic [IW-1:0] v, input logic [DW-1:0] e);
    int n;
    n = 0;
    din = v;
    din_valid = 1'b1;
    @(negedge clk);
    while (!din_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!din_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: din=0x%0h not accepted within 200 cycles", v);
    end else begin
      exp_q.push_back(e);
      acc_cnt++;
    end
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares each transfer against the scoreboard and checks hold-under-stall.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("hold_valid", dout_valid, 1);
          check("hold_data", dout, dout_prev);
        end
        if (dout_valid && dout_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", dout_valid, 0);
          end else begin
            check("dout", dout, exp_q.pop_front());
            out_cyc.push_back(cyc);
          end
        end
        stall_prev = dout_valid && !dout_ready;
        dout_prev  = dout;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [IW-1:0] rd_din [10] = '{14'd5, 14'h3FFB, 14'd7, 14'd8190, 14'h2000,
                                 14'd0, 14'h3FFF, 14'd3, 14'd1, 14'h3FFD};
`ifdef ROUND_CONVERGENT_EN
  logic [DW-1:0] rd_exp [10] = '{13'd2, 13'h1FFE, 13'd4, 13'h0FFF, 13'h1000,
                                 13'd0, 13'd0, 13'd2, 13'd0, 13'h1FFE};
`else
  logic [DW-1:0] rd_exp [10] = '{13'd3, 13'h1FFE, 13'd4, 13'h0FFF, 13'h1000,
                                 13'd0, 13'd0, 13'd2, 13'd1, 13'h1FFF};
`endif

  initial begin
    int acc0;
    logic [IW-1:0] rv;

    #1 rst = 1'b1;
    #11;
    check("rst_dout_valid", dout_valid, 0);
    check("rst_dout", dout, 0);
    check("rst_sat_flag", sat_flag, 0);
    check("rst_sat_cnt", sat_cnt, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_din_ready", din_ready, 1);
    @(posedge clk);
    #1;

    // Rounding and in-range boundaries
    dout_ready = 1'b1;
    for (int i = 0; i < 10; i++) send(rd_din[i], rd_exp[i]);
    drain();
    check("round_sat_flag", sat_flag, 0);
    check("round_sat_cnt", sat_cnt, 0);

    // Single positive saturation
    send(14'd8191, 13'h0FFF);
    drain();
    check("sat_flag_set", sat_flag, 1);
    check("sat_cnt_one", sat_cnt, 1);

    // Back-pressure: two accepts fill the pipe, then din_ready drops
    dout_ready = 1'b0;
    out_cyc.delete();
    acc0 = acc_cnt;
    fork
      begin
        for (int i = 0; i < 5; i++) send(IW'(2 * i), DW'(i));
      end
      begin
        repeat (4) @(negedge clk);
        check("bp_din_ready", din_ready, 0);
        check("bp_accepts", acc_cnt - acc0, 2);
        check("bp_dout_valid", dout_valid, 1);
        check("bp_dout", dout, 0);
        @(posedge clk);
        #1 dout_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", out_cyc.size(), 5);
    if (out_cyc.size() == 5) check("bp_no_gaps", out_cyc[4] - out_cyc[0], 4);

    // Counter saturates at all-ones
    for (int i = 0; i < 20; i++) send(14'd8191, 13'h0FFF);
    drain();
    check("cnt_hold", sat_cnt, 15);
    check("cnt_flag", sat_flag, 1);

    // Clear on the same edge the saturating sample loads into stage 2
    send(14'd8191, 13'h0FFF);
    sat_clr = 1'b1;
    @(posedge clk);
    #1 sat_clr = 1'b0;
    @(negedge clk);
    check("clr_cnt", sat_cnt, 0);
    check("clr_flag", sat_flag, 0);
    drain();

    // Async reset with two samples in flight
    send(14'd4, 13'd2);
    send(14'd6, 13'd3);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_dout_valid", dout_valid, 0);
    check("mid_rst_dout", dout, 0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_din_ready", din_ready, 1);
    check("post_rst_stale1", dout_valid, 0);
    @(negedge clk);
    check("post_rst_stale2", dout_valid, 0);
    @(posedge clk);
    #1;
    send(14'd6, 13'd3);
    @(negedge clk);
    check("lat_early", dout_valid, 0);
    @(negedge clk);
    check("lat_on", dout_valid, 1);
    drain();

    // Full throughput with random samples
    out_cyc.delete();
    for (int i = 0; i < 64; i++) begin
      rv = IW'($urandom_range(0, (1 << IW) - 1));
      send(rv, model(rv));
    end
    drain();
    check("tp_count", out_cyc.size(), 64);
    if (out_cyc.size() == 64) check("tp_no_gaps", out_cyc[63] - out_cyc[0], 63);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
